ic_lru_ctrl: RTL

Pseudo-LRU replacement controller for the instruction cache. Sits between the tag-lookup stage and the LRU state RAM: takes one lookup result per cycle (line index, hit/miss, hit way), reads the line's tree-PLRU state from the RAM, and returns the way to fill on a miss. It then writes back the updated state with the accessed or victim way marked MRU. It also clears the whole LRU RAM after reset and on flush, and forwards its own writes so back-to-back accesses to one line see fresh state.

---
 rtl/ic_lru_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ic_lru_ctrl.sv
// Tree-PLRU replacement controller: clears the LRU RAM, picks victims on miss,
// writes back updated state with a one-deep bypass for back-to-back same-line access.
module ic_lru_ctrl #(
  parameter int LINES  = 256,
  parameter int WAYS   = 8,
  parameter int LINE_W = $clog2(LINES),
  parameter int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LINE_W-1:0] req_line,
  input  logic              req_hit,
  input  logic [WAY_W-1:0]  req_way,
  output logic              rsp_valid,
  output logic [LINE_W-1:0] rsp_line,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic              lru_rd_en,
  output logic [LINE_W-1:0] lru_rd_line,
  input  logic [7:0]        lru_rd_data,
  output logic              lru_wr_en,
  output logic [LINE_W-1:0] lru_wr_line,
  output logic [7:0]        lru_wr_data
);

  localparam logic [7:0]        STATE_MASK = 8'((1 << (WAYS - 1)) - 1);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(LINES - 1);

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

  state_t              state;
  logic [LINE_W-1:0]   cnt;
  logic                s1_valid, s1_hit;
  logic [LINE_W-1:0]   s1_line;
  logic [WAY_W-1:0]    s1_way;
  logic                byp_valid;
  logic [LINE_W-1:0]   byp_line;
  logic [7:0]          byp_data;
  logic                accept;
  logic [7:0]          cur, upd;
  logic [WAY_W-1:0]    tgt;

  // Walk from the root following node bits; the path bits form the way index.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [7:0] s);
    logic [3:0]       n;
    logic [WAY_W-1:0] w;
    n = '0;
    w = '0;
    for (int l = 0; l < WAY_W; l++) begin
      w = WAY_W'({w, s[n[2:0]]});
      n = {n[2:0], 1'b0} + 4'd1 + {3'b0, s[n[2:0]]};
    end
    return w;
  endfunction

  // Each node on the path to w points to the opposite side of w.
  function automatic logic [7:0] plru_update(input logic [7:0] s, input logic [WAY_W-1:0] w);
    logic [7:0] r;
    logic [3:0] n;
    r = s;
    n = '0;
    for (int l = 0; l < WAY_W; l++) begin
      r[n[2:0]] = ~w[WAY_W-1-l];
      n = {n[2:0], 1'b0} + 4'd1 + {3'b0, w[WAY_W-1-l]};
    end
    return r;
  endfunction

  assign accept      = req_valid && req_ready;
  assign lru_rd_en   = accept;
  assign lru_rd_line = accept ? req_line : '0;

  always_comb begin
    cur = (byp_valid && byp_line == s1_line) ? byp_data : (lru_rd_data & STATE_MASK);
    tgt = s1_hit ? s1_way : plru_victim(cur);
    upd = plru_update(cur, tgt) & STATE_MASK;
  end

  assign rsp_valid = s1_valid;
  assign rsp_line  = s1_line;
  assign rsp_hit   = s1_hit;
  assign rsp_way   = s1_valid ? tgt : '0;

  // Stage-1 write has priority; it only coexists with DRAIN, never with INIT.
  always_comb begin
    lru_wr_en   = 1'b0;
    lru_wr_line = '0;
    lru_wr_data = '0;
    if (rst_n && s1_valid) begin
      lru_wr_en   = 1'b1;
      lru_wr_line = s1_line;
      lru_wr_data = upd;
    end else if (rst_n && state == INIT) begin
      lru_wr_en   = 1'b1;
      lru_wr_line = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      s1_valid  <= 1'b0;
      s1_line   <= '0;
      s1_hit    <= 1'b0;
      s1_way    <= '0;
      byp_valid <= 1'b0;
      byp_line  <= '0;
      byp_data  <= '0;
    end else begin
      s1_valid  <= accept;
      byp_valid <= lru_wr_en;
      if (accept) begin
        s1_line <= req_line;
        s1_hit  <= req_hit;
        s1_way  <= req_hit ? req_way : '0;
      end
      if (lru_wr_en) begin
        byp_line <= lru_wr_line;
        byp_data <= lru_wr_data;
      end
      case (state)
        INIT: begin
          if (flush) begin
            cnt       <= '0;
            byp_valid <= 1'b0;
          end else if (cnt == LAST_LINE) begin
            state     <= RUN;
            cnt       <= '0;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state     <= DRAIN;
            req_ready <= 1'b0;
            init_done <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          cnt       <= '0;
          byp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
